// File: rtl/ppg_multi_ch_calibrator.sv
// ppg_multi_ch_calibrator: per-channel DC/PGA calibration sequencer
// and time-slotted LED channel multiplexer for the PPG front-end.
module ppg_multi_ch_calibrator #(
  parameter int NUM_CH     = 2,
  parameter int ADC_W      = 8,
  parameter int DC_W       = 7,
  parameter int PGA_W      = 4,
  parameter int AVG_LOG2   = 5,
  parameter int TARGET_LO  = 120,
  parameter int TARGET_HI  = 130,
  parameter int CLIP_LO    = 10,
  parameter int CLIP_HI    = 245,
  parameter int SETTLE_CYC = 2,
  parameter int SLOT_CYC   = 10
) (
  input  logic                    CLK,
  input  logic                    rst_n,
  input  logic                    Find_setting,
  input  logic [ADC_W-1:0]        ADC,
  output logic [NUM_CH-1:0]       LED_EN,
  output logic [DC_W-1:0]         DC_Comp,
  output logic [PGA_W-1:0]        PGA_Gain,
  output logic [NUM_CH*ADC_W-1:0] ch_value,
  output logic [NUM_CH-1:0]       ch_valid,
  output logic [NUM_CH*DC_W-1:0]  ch_dc,
  output logic [NUM_CH*PGA_W-1:0] ch_pga,
  output logic                    calib_busy,
  output logic                    calib_done,
  output logic [NUM_CH-1:0]       cal_err
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ACC_W = ADC_W + AVG_LOG2;
  localparam int N_AVG = 1 << AVG_LOG2;
  localparam int CMAX1 = (N_AVG > SLOT_CYC) ? N_AVG : SLOT_CYC;
  localparam int CMAX  = (CMAX1 > SETTLE_CYC) ? CMAX1 : SETTLE_CYC;
  localparam int CNT_W = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    IDLE, SETTLE, DC_ACC, DC_ADJ,
    PGA_ACC, PGA_ADJ, NEXT_CH, RUN
  } state_t;

  state_t state, state_n;

  logic [CH_W-1:0]         ch, ch_n, ch_nx;
  logic                    ph_pga, ph_pga_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic [ACC_W-1:0]        acc, acc_n;
  logic [ADC_W-1:0]        mn, mn_n, mx, mx_n, avg;
  logic [NUM_CH-1:0]       led_n, valid_n, err_n;
  logic [DC_W-1:0]         dc_n;
  logic [PGA_W-1:0]        pga_n, pga_lock;
  logic [NUM_CH*ADC_W-1:0] value_n;
  logic [NUM_CH*DC_W-1:0]  chdc_n;
  logic [NUM_CH*PGA_W-1:0] chpga_n;
  logic                    busy_n, done_n;
  logic                    lo, hi, clip;

  assign ch_nx = (ch == CH_W'(NUM_CH - 1)) ? '0 : ch + CH_W'(1);
  assign avg   = acc[ACC_W-1:AVG_LOG2];
  assign lo    = avg < ADC_W'(TARGET_LO);
  assign hi    = avg > ADC_W'(TARGET_HI);
  assign clip  = (mn <= ADC_W'(CLIP_LO)) || (mx >= ADC_W'(CLIP_HI));

  // On clip, back off one gain step from the code that clipped.
  assign pga_lock = !clip ? PGA_Gain :
                    (PGA_Gain == '0) ? '0 : PGA_Gain - PGA_W'(1);

  always_comb begin
    state_n  = state;
    ch_n     = ch;
    ph_pga_n = ph_pga;
    cnt_n    = cnt;
    acc_n    = acc;
    mn_n     = mn;
    mx_n     = mx;
    led_n    = LED_EN;
    dc_n     = DC_Comp;
    pga_n    = PGA_Gain;
    value_n  = ch_value;
    valid_n  = '0;
    chdc_n   = ch_dc;
    chpga_n  = ch_pga;
    busy_n   = calib_busy;
    done_n   = calib_done;
    err_n    = cal_err;

    unique case (state)
      IDLE: ;
      SETTLE: begin
        if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
          cnt_n   = '0;
          acc_n   = '0;
          mn_n    = '1;
          mx_n    = '0;
          state_n = ph_pga ? PGA_ACC : DC_ACC;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DC_ACC: begin
        acc_n = acc + ACC_W'(ADC);
        if (cnt == CNT_W'(N_AVG - 1)) begin
          cnt_n   = '0;
          state_n = DC_ADJ;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      DC_ADJ: begin
        state_n = SETTLE;
        cnt_n   = '0;
        if (lo && DC_Comp != '0) begin
          dc_n = DC_Comp - DC_W'(1);
        end else if (hi && DC_Comp != '1) begin
          dc_n = DC_Comp + DC_W'(1);
        end else begin
          chdc_n[ch*DC_W +: DC_W] = DC_Comp;
          err_n[ch] = lo || hi;
          pga_n     = '0;
          ph_pga_n  = 1'b1;
        end
      end
      PGA_ACC: begin
        if (ADC < mn) mn_n = ADC;
        if (ADC > mx) mx_n = ADC;
        if (cnt == CNT_W'(N_AVG - 1)) begin
          cnt_n   = '0;
          state_n = PGA_ADJ;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      PGA_ADJ: begin
        cnt_n = '0;
        if (clip || PGA_Gain == '1) begin
          chpga_n[ch*PGA_W +: PGA_W] = pga_lock;
          state_n = NEXT_CH;
        end else begin
          pga_n   = PGA_Gain + PGA_W'(1);
          state_n = SETTLE;
        end
      end
      NEXT_CH: begin
        cnt_n = '0;
        if (ch != CH_W'(NUM_CH - 1)) begin
          ch_n     = ch_nx;
          led_n    = NUM_CH'(1) << ch_nx;
          dc_n     = '0;
          pga_n    = '0;
          ph_pga_n = 1'b0;
          state_n  = SETTLE;
        end else begin
          ch_n    = '0;
          led_n   = NUM_CH'(1);
          dc_n    = ch_dc[0 +: DC_W];
          pga_n   = ch_pga[0 +: PGA_W];
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = RUN;
        end
      end
      RUN: begin
        if (cnt == CNT_W'(SLOT_CYC - 1)) begin
          value_n[ch*ADC_W +: ADC_W] = ADC;
          valid_n[ch] = 1'b1;
          ch_n  = ch_nx;
          led_n = NUM_CH'(1) << ch_nx;
          dc_n  = ch_dc[ch_nx*DC_W +: DC_W];
          pga_n = ch_pga[ch_nx*PGA_W +: PGA_W];
          cnt_n = '0;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
    endcase

    // Restart wins over anything the current state was doing.
    if (Find_setting) begin
      state_n  = SETTLE;
      ch_n     = '0;
      ph_pga_n = 1'b0;
      cnt_n    = '0;
      led_n    = NUM_CH'(1);
      dc_n     = '0;
      pga_n    = '0;
      value_n  = ch_value;
      valid_n  = '0;
      chdc_n   = ch_dc;
      chpga_n  = ch_pga;
      busy_n   = 1'b1;
      done_n   = 1'b0;
      err_n    = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state      <= IDLE;
      ch         <= '0;
      ph_pga     <= 1'b0;
      cnt        <= '0;
      acc        <= '0;
      mn         <= '0;
      mx         <= '0;
      LED_EN     <= '0;
      DC_Comp    <= '0;
      PGA_Gain   <= '0;
      ch_value   <= '0;
      ch_valid   <= '0;
      ch_dc      <= '0;
      ch_pga     <= '0;
      calib_busy <= 1'b0;
      calib_done <= 1'b0;
      cal_err    <= '0;
    end else begin
      state      <= state_n;
      ch         <= ch_n;
      ph_pga     <= ph_pga_n;
      cnt        <= cnt_n;
      acc        <= acc_n;
      mn         <= mn_n;
      mx         <= mx_n;
      LED_EN     <= led_n;
      DC_Comp    <= dc_n;
      PGA_Gain   <= pga_n;
      ch_value   <= value_n;
      ch_valid   <= valid_n;
      ch_dc      <= chdc_n;
      ch_pga     <= chpga_n;
      calib_busy <= busy_n;
      calib_done <= done_n;
      cal_err    <= err_n;
    end
  end

endmodule

// File: tb/tb_ppg_multi_ch_calibrator.sv
// tb_ppg_multi_ch_calibrator: closed-loop optical front-end model
// driving a 3-channel calibrator, checked against predicted settings.
`timescale 1ns/1ps
module tb_ppg_multi_ch_calibrator;

  logic        CLK = 1'b0;
  logic        rst_n;
  logic        Find_setting;
  logic [7:0]  ADC;
  logic [2:0]  LED_EN;
  logic [6:0]  DC_Comp;
  logic [3:0]  PGA_Gain;
  logic [23:0] ch_value;
  logic [2:0]  ch_valid;
  logic [20:0] ch_dc;
  logic [11:0] ch_pga;
  logic        calib_busy;
  logic        calib_done;
  logic [2:0]  cal_err;

  ppg_multi_ch_calibrator #(.NUM_CH(3)) dut (
    .CLK(CLK), .rst_n(rst_n), .Find_setting(Find_setting), .ADC(ADC),
    .LED_EN(LED_EN), .DC_Comp(DC_Comp), .PGA_Gain(PGA_Gain),
    .ch_value(ch_value), .ch_valid(ch_valid), .ch_dc(ch_dc),
    .ch_pga(ch_pga), .calib_busy(calib_busy), .calib_done(calib_done),
    .cal_err(cal_err)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;

  // Front-end: mean = off - slope*DC, square ripple +/- amp*(PGA+1).
  int off[3], slope[3], amp[3];
  bit stuck[3];
  bit run_rand = 1'b0;
  bit tog = 1'b0;

  int exp_dc[3], exp_pga[3];
  bit exp_err[3];

  function automatic int fe(int c, int dc, int g, bit h);
    int v;
    if (stuck[c]) return 255;
    v = off[c] - slope[c] * dc;
    v = h ? v + amp[c] * (g + 1) : v - amp[c] * (g + 1);
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return v;
  endfunction

  initial begin
    int c;
    ADC = '0;
    forever begin
      @(negedge CLK);
      tog = ~tog;
      if (run_rand) begin
        ADC = 8'($urandom_range(0, 255));
      end else begin
        c = -1;
        for (int i = 0; i < 3; i++) if (LED_EN[i] === 1'b1) c = i;
        ADC = (c < 0) ? 8'd0 : 8'(fe(c, int'(DC_Comp), int'(PGA_Gain), tog));
      end
    end
  end

  // Predict the settings each channel should settle on.
  task automatic predict_all();
    int dc, avg, lv, hv, mn, mx;
    for (int c = 0; c < 3; c++) begin
      dc = 0;
      exp_err[c] = 1'b0;
      for (int it = 0; it < 1000; it++) begin
        avg = (16 * fe(c, dc, 0, 1) + 16 * fe(c, dc, 0, 0)) / 32;
        if (avg < 120 && dc > 0) dc--;
        else if (avg > 130 && dc < 127) dc++;
        else begin
          exp_err[c] = (avg < 120) || (avg > 130);
          break;
        end
      end
      exp_dc[c] = dc;
      exp_pga[c] = 15;
      for (int g = 0; g < 16; g++) begin
        lv = fe(c, dc, g, 0);
        hv = fe(c, dc, g, 1);
        mn = (lv < hv) ? lv : hv;
        mx = (lv < hv) ? hv : lv;
        if (mn <= 10 || mx >= 245) begin
          exp_pga[c] = (g == 0) ? 0 : g - 1;
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    Find_setting = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    vectors++;
    if ({LED_EN, DC_Comp, PGA_Gain} !== '0) begin
      miscompares++;
      $display("FAIL reset_drive: got led=%b dc=%0d pga=%0d, want 0", LED_EN, DC_Comp, PGA_Gain);
    end
    vectors++;
    if ({ch_value, ch_valid, ch_dc, ch_pga} !== '0) begin
      miscompares++;
      $display("FAIL reset_store: got val=%h vld=%b dc=%h pga=%h, want 0", ch_value, ch_valid, ch_dc, ch_pga);
    end
    vectors++;
    if ({calib_busy, calib_done, cal_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_status: got busy=%b done=%b err=%b, want 0", calib_busy, calib_done, cal_err);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    vectors++;
    if (LED_EN !== 3'b000 || calib_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_hold: got led=%b busy=%b, want 000 0", LED_EN, calib_busy);
    end
  endtask

  task automatic start_calib();
    @(negedge CLK);
    Find_setting = 1'b1;
    @(negedge CLK);
    Find_setting = 1'b0;
    #1;
    vectors++;
    if (LED_EN !== 3'b001 || DC_Comp !== 7'd0 || PGA_Gain !== 4'd0) begin
      miscompares++;
      $display("FAIL start_drive: got led=%b dc=%0d pga=%0d, want 001 0 0", LED_EN, DC_Comp, PGA_Gain);
    end
    vectors++;
    if (calib_busy !== 1'b1 || calib_done !== 1'b0 || cal_err !== 3'b000) begin
      miscompares++;
      $display("FAIL start_status: got busy=%b done=%b err=%b, want 1 0 000", calib_busy, calib_done, cal_err);
    end
  endtask

  task automatic finish_calib(input string tag);
    int n;
    n = 0;
    while (calib_done !== 1'b1 && n < 20000) begin
      @(negedge CLK);
      #1;
      n++;
    end
    vectors++;
    if (calib_done !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_timeout: got done=%b after %0d cycles, want 1", tag, calib_done, n);
    end
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if (ch_dc[c*7 +: 7] !== 7'(exp_dc[c]) || ch_pga[c*4 +: 4] !== 4'(exp_pga[c])
          || cal_err[c] !== exp_err[c]) begin
        miscompares++;
        $display("FAIL %s_ch%0d: got dc=%0d pga=%0d err=%b, want dc=%0d pga=%0d err=%b",
                 tag, c, ch_dc[c*7 +: 7], ch_pga[c*4 +: 4], cal_err[c],
                 exp_dc[c], exp_pga[c], exp_err[c]);
      end
    end
    vectors++;
    if (calib_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_busy: got %b, want 0", tag, calib_busy);
    end
  endtask

  task automatic test_dc_pga_directed();
    off   = '{200, 200, 0};
    slope = '{4, 4, 0};
    amp   = '{20, 5, 0};
    stuck = '{1'b0, 1'b0, 1'b1};
    predict_all();
    start_calib();
    finish_calib("directed");
  endtask

  task automatic test_run_rotation();
    int c, p;
    logic [7:0] saved;
    saved = '0;
    run_rand = 1'b1;
    for (int s = 0; s < 9; s++) begin
      c = s % 3;
      p = (s + 2) % 3;
      for (int k = 0; k < 10; k++) begin
        vectors++;
        if (LED_EN !== 3'(1 << c) || DC_Comp !== 7'(exp_dc[c]) || PGA_Gain !== 4'(exp_pga[c])) begin
          miscompares++;
          $display("FAIL run_slot s=%0d k=%0d: got led=%b dc=%0d pga=%0d, want led=%b dc=%0d pga=%0d",
                   s, k, LED_EN, DC_Comp, PGA_Gain, 3'(1 << c), exp_dc[c], exp_pga[c]);
        end
        vectors++;
        if (k == 0 && s > 0) begin
          if (ch_valid !== 3'(1 << p) || ch_value[p*8 +: 8] !== saved) begin
            miscompares++;
            $display("FAIL run_capture s=%0d: got vld=%b val=%0d, want vld=%b val=%0d",
                     s, ch_valid, ch_value[p*8 +: 8], 3'(1 << p), saved);
          end
        end else if (ch_valid !== 3'b000) begin
          miscompares++;
          $display("FAIL run_valid s=%0d k=%0d: got %b, want 000", s, k, ch_valid);
        end
        if (k == 9) saved = ADC;
        @(negedge CLK);
        #1;
      end
    end
    run_rand = 1'b0;
  endtask

  task automatic test_random_calib(input int round);
    for (int c = 0; c < 3; c++) begin
      off[c]   = $urandom_range(140, 255);
      slope[c] = $urandom_range(2, 4);
      amp[c]   = $urandom_range(1, 25);
      stuck[c] = 1'b0;
    end
    predict_all();
    start_calib();
    finish_calib($sformatf("random%0d", round));
  endtask

  task automatic test_restart();
    int old_dc[3], old_pga[3], n;
    old_dc = exp_dc;
    old_pga = exp_pga;
    for (int c = 0; c < 3; c++) begin
      off[c]   = $urandom_range(140, 255);
      slope[c] = $urandom_range(2, 4);
      amp[c]   = (c == 1) ? $urandom_range(1, 5) : $urandom_range(1, 25);
      stuck[c] = 1'b0;
    end
    predict_all();
    start_calib();
    n = 0;
    while (!(LED_EN === 3'b010 && PGA_Gain !== 4'd0) && n < 20000) begin
      @(negedge CLK);
      #1;
      n++;
    end
    vectors++;
    if (LED_EN !== 3'b010 || PGA_Gain === 4'd0) begin
      miscompares++;
      $display("FAIL restart_reach: got led=%b pga=%0d, want 010 nonzero", LED_EN, PGA_Gain);
    end
    Find_setting = 1'b1;
    @(negedge CLK);
    Find_setting = 1'b0;
    #1;
    vectors++;
    if (LED_EN !== 3'b001 || DC_Comp !== 7'd0 || PGA_Gain !== 4'd0
        || calib_busy !== 1'b1 || calib_done !== 1'b0 || cal_err !== 3'b000) begin
      miscompares++;
      $display("FAIL restart_state: got led=%b dc=%0d pga=%0d busy=%b done=%b err=%b",
               LED_EN, DC_Comp, PGA_Gain, calib_busy, calib_done, cal_err);
    end
    vectors++;
    if (ch_dc[7 +: 7] !== 7'(exp_dc[1]) || ch_dc[14 +: 7] !== 7'(old_dc[2])
        || ch_pga[4 +: 4] !== 4'(old_pga[1]) || ch_pga[8 +: 4] !== 4'(old_pga[2])) begin
      miscompares++;
      $display("FAIL restart_held: got dc1=%0d dc2=%0d pga1=%0d pga2=%0d, want %0d %0d %0d %0d",
               ch_dc[7 +: 7], ch_dc[14 +: 7], ch_pga[4 +: 4], ch_pga[8 +: 4],
               exp_dc[1], old_dc[2], old_pga[1], old_pga[2]);
    end
    finish_calib("restart");
  endtask

  task automatic test_reset_mid_run();
    repeat (15) @(negedge CLK);
    rst_n = 1'b0;
    @(negedge CLK);
    #1;
    vectors++;
    if ({LED_EN, DC_Comp, PGA_Gain, ch_valid, calib_busy, calib_done, cal_err} !== '0) begin
      miscompares++;
      $display("FAIL runreset_drive: got led=%b dc=%0d pga=%0d vld=%b busy=%b done=%b err=%b, want 0",
               LED_EN, DC_Comp, PGA_Gain, ch_valid, calib_busy, calib_done, cal_err);
    end
    vectors++;
    if ({ch_value, ch_dc, ch_pga} !== '0) begin
      miscompares++;
      $display("FAIL runreset_store: got val=%h dc=%h pga=%h, want 0", ch_value, ch_dc, ch_pga);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_dc_pga_directed();
    test_run_rotation();
    test_random_calib(1);
    test_random_calib(2);
    test_restart();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
